// File: rtl/and5_sweep_ctrl.sv
// and5_sweep_ctrl: self-checking sweep controller for a 5-input AND gate.
//
// On an accepted start it walks gate_in through all 32 vectors. Each vector is
// held for SETTLE_CYC cycles, then checked for one cycle against &vec. The
// block counts mismatches and records the first failing vector.
//
// Parameters:
//   SETTLE_CYC  cycles each vector is held before sampling (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      sweep request, honoured only in idle or done
//   gate_in    vector driven to the gate (bit0 = in1 .. bit4 = in5)
//   gate_out   gate output, synchronous to clk
//   busy       sweep in progress
//   done       sweep finished, held until next accepted start or reset
//   pass       done and no mismatches
//   err_count  number of mismatching vectors (0..32)
//   fail_vec   first mismatching vector, 0 if none
//
// Build option:
//   AND5_SWEEP_STOP_ON_FAIL_EN  end the sweep at the first mismatch; gate_in
//                               then holds the failing vector.

module and5_sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] gate_in,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [4:0] fail_vec
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    localparam logic [3:0] CntLast = 4'(SETTLE_CYC - 1);

    state_e     state_q, state_d;
    logic [4:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] err_q, err_d;
    logic [4:0] fail_vec_q, fail_vec_d;
    logic       fail_seen_q, fail_seen_d;
    logic       mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            vec_q       <= 5'd0;
            cnt_q       <= 4'd0;
            err_q       <= 6'd0;
            fail_vec_q  <= 5'd0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fail_vec_q  <= fail_vec_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign mismatch = (gate_out != (&vec_q));

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        fail_vec_d  = fail_vec_q;
        fail_seen_d = fail_seen_q;

        unique case (state_q)
            StIdle, StDone: begin
                // A restart from done clears all results on the same edge.
                if (start) begin
                    vec_d       = 5'd0;
                    cnt_d       = 4'd0;
                    err_d       = 6'd0;
                    fail_vec_d  = 5'd0;
                    fail_seen_d = 1'b0;
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CntLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + 6'd1;
                    if (!fail_seen_q) begin
                        fail_vec_d  = vec_q;
                        fail_seen_d = 1'b1;
                    end
                end
`ifdef AND5_SWEEP_STOP_ON_FAIL_EN
                if (mismatch || (vec_q == 5'd31)) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 5'd1;
                    cnt_d   = 4'd0;
                    state_d = StSettle;
                end
`else
                if (vec_q == 5'd31) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 5'd1;
                    cnt_d   = 4'd0;
                    state_d = StSettle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign gate_in   = vec_q;
    assign busy      = (state_q == StSettle) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == 6'd0);
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_and5_sweep_ctrl.sv
// Bench for and5_sweep_ctrl (default SETTLE_CYC = 2). A behavioural gate with
// selectable faults drives gate_out; expected sweep results are computed by
// enumerating all 32 vectors against the ideal AND.

module tb_and5_sweep_ctrl;

    localparam int Per   = 3;        // SETTLE_CYC + 1 cycles per vector
    localparam int Limit = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] gate_in;
    logic       gate_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_count;
    logic [4:0] fail_vec;

    int          cmp = 0;
    int          bad = 0;
    int          gate_mode = 0;
    logic [31:0] fault_mask = 32'd0;

    logic [4:0] tr_gate [0:Limit-1];
    logic       tr_busy [0:Limit-1];
    logic [5:0] tr_err  [0:Limit-1];

    always #5 clk = ~clk;

    // Gate under test: 0 ideal, 1 stuck-0, 2 stuck-1, 3 in3 forced high,
    // 4 ideal output flipped wherever fault_mask has a 1.
    function automatic logic gate_fn(input int mode, input logic [31:0] m, input logic [4:0] v);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return &(v | 5'b00100);
            4:       return (&v) ^ m[v];
            default: return &v;
        endcase
    endfunction

    assign gate_out = gate_fn(gate_mode, fault_mask, gate_in);

    and5_sweep_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate_in   (gate_in),
        .gate_out  (gate_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    // Expected outcome of a sweep for the current gate.
    task automatic model(output int err, output int first, output int cyc,
                         output logic [4:0] final_vec);
        bit stop;
        err   = 0;
        first = -1;
        stop  = 0;
        for (int v = 0; v < 32; v++) begin
            if (!stop && (gate_fn(gate_mode, fault_mask, 5'(v)) != (v == 31))) begin
                err++;
                if (first < 0) first = v;
`ifdef AND5_SWEEP_STOP_ON_FAIL_EN
                stop = 1;
`endif
            end
        end
        cyc       = 32 * Per;
        final_vec = 5'd31;
`ifdef AND5_SWEEP_STOP_ON_FAIL_EN
        if (first >= 0) begin
            cyc       = (first + 1) * Per;
            final_vec = 5'(first);
        end
`endif
    endtask

    // Pulse start, then record one sample per cycle until done (bounded).
    // glitch_at pulses start again while busy; abort_at returns mid-sweep.
    task automatic do_sweep(input int glitch_at, input int abort_at, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (!done && cycles < Limit) begin
            if (cycles == abort_at) return;
            tr_gate[cycles] = gate_in;
            tr_busy[cycles] = busy;
            tr_err[cycles]  = err_count;
            start = (cycles == glitch_at);
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        cmp++;
        if ({gate_in, busy, done, pass, err_count, fail_vec} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {gate_in, busy, done, pass, err_count, fail_vec});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_correct_gate;
        int cycles, err, first, cyc;
        int bad_k;
        logic [4:0] fv;
        gate_mode = 0;
        model(err, first, cyc, fv);
        do_sweep(-1, -1, cycles);
        cmp++;
        if (cycles !== cyc) begin
            bad++;
            $display("FAIL correct_cycles: got %0d expected %0d", cycles, cyc);
        end
        bad_k = -1;
        for (int k = 0; k < cycles && k < Limit; k++)
            if (bad_k < 0 && (tr_gate[k] !== 5'(k / Per) || tr_busy[k] !== 1'b1)) bad_k = k;
        cmp++;
        if (bad_k >= 0) begin
            bad++;
            $display("FAIL correct_trace: cycle %0d gate_in=%0d busy=%b expected %0d 1",
                     bad_k, tr_gate[bad_k], tr_busy[bad_k], bad_k / Per);
        end
        cmp++;
        if ({done, pass, busy} !== 3'b110) begin
            bad++;
            $display("FAIL correct_flags: done/pass/busy got %b expected 110", {done, pass, busy});
        end
        cmp++;
        if (err_count !== 6'd0 || fail_vec !== 5'd0 || gate_in !== 5'd31) begin
            bad++;
            $display("FAIL correct_results: err=%0d fail=%0d gate_in=%0d expected 0 0 31",
                     err_count, fail_vec, gate_in);
        end
    endtask

    task automatic test_gate_fault(input string name, input int mode, input logic [31:0] m);
        int cycles, err, first, cyc;
        logic [4:0] fv;
        gate_mode  = mode;
        fault_mask = m;
        model(err, first, cyc, fv);
        do_sweep(-1, -1, cycles);
        cmp++;
        if (cycles !== cyc) begin
            bad++;
            $display("FAIL %s_cycles: got %0d expected %0d", name, cycles, cyc);
        end
        cmp++;
        if (err_count !== 6'(err)) begin
            bad++;
            $display("FAIL %s_err_count: got %0d expected %0d", name, err_count, err);
        end
        cmp++;
        if (fail_vec !== ((first < 0) ? 5'd0 : 5'(first))) begin
            bad++;
            $display("FAIL %s_fail_vec: got %0d expected %0d", name, fail_vec,
                     (first < 0) ? 0 : first);
        end
        cmp++;
        if ({done, busy, pass} !== {2'b10, err == 0}) begin
            bad++;
            $display("FAIL %s_flags: done/busy/pass got %b expected %b", name,
                     {done, busy, pass}, {2'b10, err == 0});
        end
        cmp++;
        if (gate_in !== fv) begin
            bad++;
            $display("FAIL %s_gate_in_hold: got %0d expected %0d", name, gate_in, fv);
        end
    endtask

    task automatic test_rst_mid_sweep;
        int cycles;
        gate_mode = 0;
        do_sweep(-1, 40, cycles);
        rst = 1'b1;
        #1;
        cmp++;
        if ({gate_in, busy, done, pass, err_count, fail_vec} !== 19'd0) begin
            bad++;
            $display("FAIL rst_mid_sweep: got %b expected all zero",
                     {gate_in, busy, done, pass, err_count, fail_vec});
        end
        @(negedge clk);
        rst = 1'b0;
        do_sweep(-1, -1, cycles);
        cmp++;
        if (cycles !== 32 * Per || pass !== 1'b1) begin
            bad++;
            $display("FAIL rst_resweep: cycles=%0d pass=%b expected %0d 1", cycles, pass, 32 * Per);
        end
    endtask

    task automatic test_start_while_busy;
        int cycles, bad_k;
        gate_mode = 0;
        do_sweep(10, -1, cycles);
        bad_k = -1;
        for (int k = 0; k < cycles && k < Limit; k++)
            if (bad_k < 0 && tr_gate[k] !== 5'(k / Per)) bad_k = k;
        cmp++;
        if (cycles !== 32 * Per || bad_k >= 0) begin
            bad++;
            $display("FAIL start_while_busy: cycles=%0d first_bad_cycle=%0d expected %0d -1",
                     cycles, bad_k, 32 * Per);
        end
    endtask

    // Previous sweep left errors recorded; restart from done must clear them.
    task automatic test_back_to_back;
        int cycles;
        gate_mode = 0;
        do_sweep(-1, -1, cycles);
        cmp++;
        if (tr_err[0] !== 6'd0) begin
            bad++;
            $display("FAIL b2b_clear: err_count after restart got %0d expected 0", tr_err[0]);
        end
        cmp++;
        if (cycles !== 32 * Per || pass !== 1'b1 || err_count !== 6'd0) begin
            bad++;
            $display("FAIL b2b_result: cycles=%0d pass=%b err=%0d expected %0d 1 0",
                     cycles, pass, err_count, 32 * Per);
        end
    endtask

    initial begin
        test_reset();
        test_correct_gate();
        test_gate_fault("stuck0", 1, 32'd0);
        test_gate_fault("stuck1", 2, 32'd0);
        test_gate_fault("in3_high", 3, 32'd0);
        test_rst_mid_sweep();
        test_start_while_busy();
        for (int i = 0; i < 4; i++)
            test_gate_fault("random", 4, (i == 0) ? 32'h8000_0001 : ($urandom & $urandom));
        test_gate_fault("stuck1_again", 2, 32'd0);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
